// File: rtl/mac_accumulator_if.sv
// Handshake bundle between the MAC accumulate stage and its neighbours:
// job control, product input stream, and result output stream.
interface mac_accumulator_if #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
);
    logic              Start;
    logic [LEN_W-1:0]  Length;
    logic [ACC_W-1:0]  Bias;
    logic              In_Valid;
    logic              In_Ready;
    logic [PROD_W-1:0] Product;
    logic              Out_Valid;
    logic              Out_Ready;
    logic [ACC_W-1:0]  Acc_Out;
    logic              Overflow;
    logic              Busy;

    modport master (
        output Start, Length, Bias, In_Valid, Product, Out_Ready,
        input  In_Ready, Out_Valid, Acc_Out, Overflow, Busy
    );

    modport slave (
        input  Start, Length, Bias, In_Valid, Product, Out_Ready,
        output In_Ready, Out_Valid, Acc_Out, Overflow, Busy
    );
endinterface

// File: rtl/mac_accumulator.sv
// Saturating accumulate stage: sums Length unsigned product terms onto a bias
// and hands the dot-product result to the activation stage via valid/ready.
module mac_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input logic              clk,
    input logic              rst_n,
    mac_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [LEN_W-1:0]  count;
    logic [LEN_W-1:0]  len_q;
    logic              overflow;
    logic              out_valid;
    logic              busy;

    logic              accept;
    logic [ACC_W:0]    sum;

    assign accept = bus.In_Valid && (state == ACCUM);
    // One guard bit above the accumulator exposes any overflow of the add.
    assign sum    = {1'b0, acc} + (ACC_W + 1)'(bus.Product);

    assign bus.In_Ready  = (state == ACCUM);
    assign bus.Out_Valid = out_valid;
    assign bus.Acc_Out   = acc;
    assign bus.Overflow  = overflow;
    assign bus.Busy      = busy;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            len_q     <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        acc      <= bus.Bias;
                        count    <= '0;
                        overflow <= 1'b0;
                        len_q    <= bus.Length;
                        busy     <= 1'b1;
                        if (bus.Length == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end

                ACCUM: begin
                    if (accept) begin
                        if (sum[ACC_W]) begin
                            acc      <= '1;
                            overflow <= 1'b1;
                        end else begin
                            acc <= sum[ACC_W-1:0];
                        end
                        count <= count + LEN_W'(1);
                        if (count == len_q - LEN_W'(1)) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // Start is deliberately not examined here; new jobs begin only from IDLE.
                    if (bus.Out_Ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
